accumulator_seq: RTL and testbench

ACCUMULATOR_SEQ -- requirements
Module: accumulator_seq

---
 rtl/accumulator_seq.sv | 90 +++++++++
 tb/tb_accumulator_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_seq.sv
// Sequential accumulator for a multiplier's product stream.
// Sums iLen products per job and hands the result off with valid/ready.
module accumulator_seq #(
  parameter int BITWIDTH = 32,
  parameter int ACCWIDTH = 2*BITWIDTH+8,
  parameter int LENWIDTH = 8
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iClr,
  input  logic                  iStart,
  input  logic [LENWIDTH-1:0]   iLen,
  input  logic                  iValid,
  input  logic [2*BITWIDTH-1:0] iData,
  output logic                  oReady,
  output logic                  oValid,
  output logic [ACCWIDTH-1:0]   oData,
  input  logic                  iReady,
  output logic                  oBusy,
  output logic                  oOvf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t                state;
  logic [LENWIDTH-1:0]   count;
  logic [ACCWIDTH-1:0]   acc;
  logic                  ovf;
  logic [ACCWIDTH:0]     sum;

  // One extra bit captures the carry that feeds the sticky overflow flag.
  assign sum = {1'b0, acc}
             + {{(ACCWIDTH+1-2*BITWIDTH){1'b0}}, iData};

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else if (iClr) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            acc <= '0;
            ovf <= 1'b0;
            if (iLen == '0) begin
              state <= DONE;
            end else begin
              count <= iLen;
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (iValid) begin
            acc   <= sum[ACCWIDTH-1:0];
            ovf   <= ovf | sum[ACCWIDTH];
            count <= count - 1'b1;
            if (count == LENWIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (iReady) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign oReady = (state == ACC);
  assign oValid = (state == DONE);
  assign oBusy  = (state != IDLE);
  assign oData  = acc;
  assign oOvf   = ovf;

endmodule

// File: tb/tb_accumulator_seq.sv
// Directed bench for accumulator_seq (BITWIDTH=4, ACCWIDTH=10).
// Expected sums are queued at job start and popped on oValid.
module tb_accumulator_seq;

  logic       iClk = 1'b0;
  logic       iRstN;
  logic       iClr;
  logic       iStart;
  logic [7:0] iLen;
  logic       iValid;
  logic [7:0] iData;
  logic       oReady;
  logic       oValid;
  logic [9:0] oData;
  logic       iReady;
  logic       oBusy;
  logic       oOvf;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  accumulator_seq #(
    .BITWIDTH(4),
    .ACCWIDTH(10),
    .LENWIDTH(8)
  ) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .iStart(iStart),
    .iLen  (iLen),
    .iValid(iValid),
    .iData (iData),
    .oReady(oReady),
    .oValid(oValid),
    .oData (oData),
    .iReady(iReady),
    .oBusy (oBusy),
    .oOvf  (oOvf)
  );

  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_ready"}, 32'(oReady), 0);
    check({tag, "_valid"}, 32'(oValid), 0);
    check({tag, "_busy"},  32'(oBusy),  0);
    check({tag, "_data"},  32'(oData),  0);
    check({tag, "_ovf"},   32'(oOvf),   0);
  endtask

  task automatic start(input int len);
    iStart = 1'b1;
    iLen   = 8'(len);
    step();
    iStart = 1'b0;
    iLen   = 8'd0;
  endtask

  task automatic beat(input int v);
    check("beat_ready", 32'(oReady), 1);
    iValid = 1'b1;
    iData  = 8'(v);
    step();
    iValid = 1'b0;
    iData  = 8'd0;
  endtask

  // Bounded wait for oValid, then compare against the scoreboard head.
  task automatic expect_result(input string tag, input int budget);
    int n = 0;
    while (!oValid && n < budget) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(oValid), 1);
    if (oValid) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check({tag, "_data"}, 32'(oData), 32'(e));
      end
    end
  endtask

  task automatic handoff(input string tag);
    iReady = 1'b1;
    step();
    iReady = 1'b0;
    check({tag, "_idle_busy"},  32'(oBusy),  0);
    check({tag, "_idle_valid"}, 32'(oValid), 0);
  endtask

  initial begin
    iRstN  = 1'b0;
    iClr   = 1'b0;
    iStart = 1'b0;
    iLen   = 8'd0;
    iValid = 1'b0;
    iData  = 8'd0;
    iReady = 1'b0;
    #12;
    check_idle_zero("reset");
    step();
    iRstN = 1'b1;

    // Basic sum: result appears one cycle after the last beat.
    exp_q.push_back(60);
    start(3);
    check("basic_busy", 32'(oBusy), 1);
    beat(10);
    beat(20);
    beat(30);
    check("basic_valid_now", 32'(oValid), 1);
    expect_result("basic", 0);
    check("basic_ovf", 32'(oOvf), 0);
    handoff("basic");

    // Gaps in the input stream, then downstream backpressure.
    exp_q.push_back(12);
    start(2);
    beat(5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("gap_ready", 32'(oReady), 1);
      check("gap_data",  32'(oData),  5);
    end
    beat(7);
    expect_result("gap", 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_valid", 32'(oValid), 1);
      check("bp_data",  32'(oData),  12);
    end
    handoff("bp");
    check("bp_hold_data", 32'(oData), 12);

    // Overflow wraps modulo 1024 and sets the sticky flag.
    exp_q.push_back((5 * 255) % 1024);
    start(5);
    for (int i = 0; i < 5; i++) beat(255);
    expect_result("ovf", 0);
    check("ovf_flag", 32'(oOvf), 1);
    handoff("ovf");
    check("ovf_hold_idle", 32'(oOvf), 1);
    exp_q.push_back(1);
    start(1);
    check("ovf_cleared", 32'(oOvf), 0);
    beat(1);
    expect_result("ovf_next", 0);
    handoff("ovf_next");

    // Zero-length job goes straight to DONE.
    exp_q.push_back(0);
    start(0);
    check("zero_ready", 32'(oReady), 0);
    expect_result("zero", 0);
    handoff("zero");

    // Synchronous clear mid-job.
    start(4);
    beat(9);
    beat(9);
    check("clr_partial", 32'(oData), 18);
    iClr = 1'b1;
    step();
    iClr = 1'b0;
    check_idle_zero("clr");
    for (int i = 0; i < 3; i++) begin
      step();
      check("clr_no_valid", 32'(oValid), 0);
    end

    // Asynchronous reset mid-job, pulsed between clock edges.
    start(4);
    beat(9);
    beat(9);
    #2 iRstN = 1'b0;
    #1;
    check_idle_zero("arst");
    #1 iRstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_no_valid", 32'(oValid), 0);
    end
    exp_q.push_back(3);
    start(1);
    check("arst_restart", 32'(oReady), 1);
    beat(3);
    expect_result("arst_job", 0);
    handoff("arst_job");

    // iStart during ACC must not disturb the running job.
    exp_q.push_back(6);
    start(3);
    beat(1);
    iStart = 1'b1;
    iLen   = 8'd50;
    step();
    iStart = 1'b0;
    iLen   = 8'd0;
    check("ign_data", 32'(oData), 1);
    beat(2);
    beat(3);
    expect_result("ign", 0);

    // Back-to-back: new start right after the handoff cycle.
    handoff("b2b_first");
    exp_q.push_back(9);
    start(2);
    check("b2b_acc", 32'(oData), 0);
    beat(4);
    beat(5);
    expect_result("b2b", 0);
    handoff("b2b_second");
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
